// File: rtl/spi_slave.sv
// SPI target endpoint: pins are synchronized into clk, words move through a
// one-entry TX holding register and a single-cycle RX strobe.
module spi_slave #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       CPOL      = 0,
  parameter int unsigned       CPHA      = 0,
  parameter int unsigned       MSB_FIRST = 1,
  parameter logic [DATA_W-1:0] TX_FILL   = '1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sclk,
  input  logic              nss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int unsigned     CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic            IDLE_LVL = (CPOL != 0);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic nss_s1, nss_s2, nss_s3;
  logic mosi_s1, mosi_s2;

  logic lead_edge, trail_edge, nss_fall, nss_rise;
  logic active, sample_en, shift_en, load;

  logic              hold_full;
  logic [DATA_W-1:0] hold_q, tx_sr, rx_sr, load_word, rx_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic              word_done, miso_q;

  // sclk sync flops reset to the idle level so release never fakes an edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_s1 <= IDLE_LVL;
      sclk_s2 <= IDLE_LVL;
      sclk_s3 <= IDLE_LVL;
      nss_s1  <= 1'b1;
      nss_s2  <= 1'b1;
      nss_s3  <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      nss_s1  <= nss;
      nss_s2  <= nss_s1;
      nss_s3  <= nss_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    lead_edge  = (sclk_s3 == IDLE_LVL) && (sclk_s2 != IDLE_LVL);
    trail_edge = (sclk_s3 != IDLE_LVL) && (sclk_s2 == IDLE_LVL);
    nss_fall   = nss_s3 && !nss_s2;
    nss_rise   = !nss_s3 && nss_s2;

    state_nxt = state;
    case (state)
      IDLE:    if (nss_fall) state_nxt = SHIFT;
      SHIFT:   if (nss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    active    = (state == SHIFT) && !nss_s2;
    sample_en = active && ((CPHA != 0) ? trail_edge : lead_edge);
    shift_en  = active && ((CPHA != 0) ? lead_edge : trail_edge);

    load = 1'b0;
    if (CPHA != 0) load = shift_en && (bit_cnt == '0);
    else           load = ((state == IDLE) && nss_fall) || (shift_en && word_done);

    load_word = hold_full ? hold_q : TX_FILL;
    rx_next   = (MSB_FIRST != 0) ? {rx_sr[DATA_W-2:0], mosi_s2}
                                 : {mosi_s2, rx_sr[DATA_W-1:1]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_full   <= 1'b0;
      hold_q      <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      word_done   <= 1'b0;
      miso_q      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      // load is ordered before the write so a same-cycle write survives for the next word
      if (load) begin
        hold_full   <= 1'b0;
        tx_underrun <= !hold_full;
      end
      if (tx_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_q    <= tx_data;
      end

      if (nss_rise) begin
        tx_sr     <= '0;
        rx_sr     <= '0;
        bit_cnt   <= '0;
        word_done <= 1'b0;
        miso_q    <= 1'b0;
      end else begin
        if (load) begin
          tx_sr     <= load_word;
          miso_q    <= (MSB_FIRST != 0) ? load_word[DATA_W-1] : load_word[0];
          word_done <= 1'b0;
        end else if (shift_en) begin
          tx_sr  <= (MSB_FIRST != 0) ? {tx_sr[DATA_W-2:0], 1'b0} : {1'b0, tx_sr[DATA_W-1:1]};
          miso_q <= (MSB_FIRST != 0) ? tx_sr[DATA_W-2] : tx_sr[1];
        end
        if (sample_en) begin
          rx_sr <= rx_next;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt   <= '0;
            rx_data   <= rx_next;
            rx_valid  <= 1'b1;
            word_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  assign miso_oe  = !nss_s2;
  assign miso     = miso_q && miso_oe;
  assign tx_ready = !hold_full;
  assign busy     = (state == SHIFT);

endmodule
